// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider sequencer for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: zero-divisor / overflow cases skip the CALC phase.
module div_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;

  // funct3[2] is always set by the decoder; only bits [1:0] select the op.
  logic unused_f3;
  assign unused_f3 = funct3[2];

  logic            is_signed, a_neg, b_neg, prep_dz, prep_ovf;
  logic [XLEN-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [XLEN:0]   rem_sh, trial;

  assign is_signed = ~f3_q[0];
  assign a_neg     = is_signed & a_q[XLEN-1];
  assign b_neg     = is_signed & b_q[XLEN-1];
  assign abs_a     = a_neg ? ('0 - a_q) : a_q;
  assign abs_b     = b_neg ? ('0 - b_q) : b_q;
  assign prep_dz   = (b_q == '0);
  assign prep_ovf  = is_signed & (a_q == MIN_NEG) & (b_q == '1);

  // Shifted-in dividend bit enters the partial remainder before the trial subtract.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    q_fix = qneg_q ? ('0 - quo_q) : quo_q;
    r_fix = rneg_q ? ('0 - rem_q) : rem_q;
    if (dz_q) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (ovf_q) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          f3_d    = funct3[1:0];
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        quo_d   = abs_a;
        dvs_d   = abs_b;
        rem_d   = '0;
        cnt_d   = CW'(XLEN - 1);
        qneg_d  = a_neg ^ b_neg;
        rneg_d  = a_neg;
        dz_d    = prep_dz;
        ovf_d   = prep_ovf;
        state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
        if (prep_dz || prep_ovf) state_d = S_FIX;
`endif
      end
      S_CALC: begin
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = f3_q[1] ? r_fix : q_fix;
        state_d  = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything except IDLE; a flushed FIX must not publish.
    if (flush && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign stall  = ((state_q == S_IDLE) && start && !flush) ||
                  (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model plus directed vectors.
// Honours DIV_EARLY_OUT_EN for the expected latency of zero-divisor / overflow cases.
module tb_div_sequencer;
  localparam int unsigned XLEN = 32;
  localparam int NORMAL_LAT = 35;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 3;
`else
  localparam int SPECIAL_LAT = 35;
`endif

  logic        clk = 1'b0;
  logic        nrst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic        busy, stall, done;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic special_case(input logic [2:0] f3, input logic [31:0] a, b);
    return (b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, b);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (!f3[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  // Reference: age counts cycles since acceptance; done falls on age == latency.
  bit          m_active = 1'b0;
  int          m_age    = 0;
  int          m_lat    = 0;
  logic [31:0] m_pend   = '0;
  logic [31:0] m_held   = '0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_held   <= '0;
    end else if (!m_active) begin
      if (start && !flush) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_lat    <= special_case(funct3, op_a, op_b) ? SPECIAL_LAT : NORMAL_LAT;
        m_pend   <= ref_result(funct3, op_a, op_b);
      end
    end else if (flush || m_age == m_lat) begin
      m_active <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (m_age + 1 == m_lat) m_held <= m_pend;
    end
  end

  logic e_busy, e_stall, e_done;
  always @(negedge clk) begin
    if (chk_en) begin
      e_busy  = m_active;
      e_done  = m_active && (m_age == m_lat);
      e_stall = m_active ? (m_age < m_lat) : (start && !flush);
      chk("cyc_busy",   {31'b0, busy},  {31'b0, e_busy});
      chk("cyc_stall",  {31'b0, stall}, {31'b0, e_stall});
      chk("cyc_done",   {31'b0, done},  {31'b0, e_done});
      chk("cyc_result", result, m_held);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a, b,
                        input logic [31:0] exp_r, input int exp_lat, input bit hold);
    int cyc;
    bit seen;
    chk({nm, "_model"}, ref_result(f3, a, b), exp_r);
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    chk({nm, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({nm, "_res"}, result, exp_r);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst   = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'h4;
    op_a   = '0;
    op_b   = '0;
    #1 nrst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_busy",   {31'b0, busy},  32'h0);
    chk("rst_stall",  {31'b0, stall}, 32'h0);
    chk("rst_done",   {31'b0, done},  32'h0);
    chk("rst_result", result,         32'h0);
    repeat (2) tick();
    nrst = 1'b1;
    tick();

    run_op("divu_100_7",   3'h5, 32'd100,       32'd7,         32'd14,        NORMAL_LAT,  1'b0);
    run_op("remu_100_7",   3'h7, 32'd100,       32'd7,         32'd2,         NORMAL_LAT,  1'b0);
    run_op("rem_m7_2",     3'h6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NORMAL_LAT,  1'b0);
    run_op("div_m7_2",     3'h4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NORMAL_LAT,  1'b0);
    run_op("div_5_0",      3'h4, 32'd5,         32'd0,         32'hFFFF_FFFF, SPECIAL_LAT, 1'b0);
    run_op("rem_5_0",      3'h6, 32'd5,         32'd0,         32'd5,         SPECIAL_LAT, 1'b0);
    run_op("divu_5_0",     3'h5, 32'd5,         32'd0,         32'hFFFF_FFFF, SPECIAL_LAT, 1'b0);
    run_op("rem_m7_0",     3'h6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPECIAL_LAT, 1'b0);
    run_op("div_ovf",      3'h4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT, 1'b0);
    run_op("rem_ovf",      3'h6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         SPECIAL_LAT, 1'b0);
    run_op("divu_min_m1",  3'h5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         NORMAL_LAT,  1'b0);
    run_op("remu_min_m1",  3'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORMAL_LAT,  1'b0);
    run_op("illegal_f3_1", 3'h1, 32'd100,       32'd7,         32'd14,        NORMAL_LAT,  1'b0);
    run_op("div_m7_m2",    3'h4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         NORMAL_LAT,  1'b0);

    // start and flush together in IDLE: nothing accepted
    funct3 = 3'h5; op_a = 32'd50; op_b = 32'd5;
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("sf_busy", {31'b0, busy}, 32'h0);

    // abort mid-CALC in cycle 10, restart in cycle 11
    funct3 = 3'h5; op_a = 32'd1000; op_b = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("fl_busy_c10", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy",   {31'b0, busy},  32'h0);
    chk("fl_stall",  {31'b0, stall}, 32'h0);
    chk("fl_done",   {31'b0, done},  32'h0);
    chk("fl_result", result,         32'd3);
    run_op("divu_9_3", 3'h5, 32'd9, 32'd3, 32'd3, NORMAL_LAT, 1'b0);

    // asynchronous reset mid-CALC
    funct3 = 3'h5; op_a = 32'h0000_FFFF; op_b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    nrst = 1'b0;
    #1;
    chk("mrst_busy",   {31'b0, busy},  32'h0);
    chk("mrst_stall",  {31'b0, stall}, 32'h0);
    chk("mrst_done",   {31'b0, done},  32'h0);
    chk("mrst_result", result,         32'h0);
    repeat (2) tick();
    nrst = 1'b1;
    tick();

    // start held high through DONE: one op per IDLE acceptance
    run_op("divu_max_1", 3'h5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORMAL_LAT, 1'b1);
    run_op("remu_hold",  3'h7, 32'd100,       32'd7, 32'd2,         NORMAL_LAT, 1'b0);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
